// File: rtl/trace_step_sequencer.sv
// Deserialises a 32-bit trace word stream into 560-bit tiny86 steps and checks
// each step's register fields against the post-state tiny86 produced for the previous step.
module trace_step_sequencer #(
  parameter int          COUNT_W     = 32,
  parameter logic [31:0] EFLAGS_MASK = 32'h0000_08D5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic [559:0]       step,
  output logic               step_valid,
  input  logic [319:0]       post_state,
  output logic               done,
  output logic               ok,
  output logic               err_framing,
  output logic [9:0]         mismatch_mask,
  output logic [COUNT_W-1:0] step_count,
  output logic [COUNT_W-1:0] fail_step
);

  typedef enum logic [1:0] {LOAD, EVAL, PASS, FAIL} state_t;

  state_t             state_q, state_d;
  logic [4:0]         word_cnt_q, word_cnt_d;
  logic [559:0]       step_q, step_d;
  logic [319:0]       pred_q, pred_d;
  logic               have_prev_q, have_prev_d;
  logic               last_seen_q, last_seen_d;
  logic               err_framing_q, err_framing_d;
  logic [9:0]         mismatch_mask_q, mismatch_mask_d;
  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic [COUNT_W-1:0] fail_step_q, fail_step_d;

  logic [9:0] reg_mm;
  logic [9:0] word_lsb;

  // Word k lands at step[559-32k -: 32], i.e. its LSB sits at 528-32k.
  assign word_lsb = 10'd528 - {word_cnt_q, 5'b00000};

  // Register gi (0 = eax .. 9 = eflags) against the prediction; only eflags is masked.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cmp
      localparam logic [31:0] CMP_MASK = (gi == 9) ? EFLAGS_MASK : 32'hFFFF_FFFF;
      assign reg_mm[9-gi] =
        ((step_q[463-32*gi -: 32] ^ pred_q[319-32*gi -: 32]) & CMP_MASK) != 32'h0;
    end
  endgenerate

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    step_d          = step_q;
    pred_d          = pred_q;
    have_prev_d     = have_prev_q;
    last_seen_d     = last_seen_q;
    err_framing_d   = err_framing_q;
    mismatch_mask_d = mismatch_mask_q;
    step_count_d    = step_count_q;
    fail_step_d     = fail_step_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (in_last && (word_cnt_q != 5'd17)) begin
            state_d       = FAIL;
            err_framing_d = 1'b1;
          end else if (word_cnt_q == 5'd17) begin
            step_d[15:0] = in_data[31:16];
            last_seen_d  = in_last;
            state_d      = EVAL;
          end else begin
            step_d[word_lsb +: 32] = in_data;
            word_cnt_d             = word_cnt_q + 5'd1;
          end
        end
      end
      EVAL: begin
        pred_d      = post_state;
        have_prev_d = 1'b1;
        if (step_count_q != {COUNT_W{1'b1}})
          step_count_d = step_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        if (have_prev_q && (|reg_mm)) begin
          state_d         = FAIL;
          mismatch_mask_d = reg_mm;
          fail_step_d     = step_count_q;
        end else if (last_seen_q) begin
          state_d = PASS;
        end else begin
          state_d    = LOAD;
          word_cnt_d = 5'd0;
        end
      end
      PASS:    state_d = PASS;
      FAIL:    state_d = FAIL;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= LOAD;
      word_cnt_q      <= 5'd0;
      step_q          <= '0;
      pred_q          <= '0;
      have_prev_q     <= 1'b0;
      last_seen_q     <= 1'b0;
      err_framing_q   <= 1'b0;
      mismatch_mask_q <= 10'd0;
      step_count_q    <= '0;
      fail_step_q     <= '0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      step_q          <= step_d;
      pred_q          <= pred_d;
      have_prev_q     <= have_prev_d;
      last_seen_q     <= last_seen_d;
      err_framing_q   <= err_framing_d;
      mismatch_mask_q <= mismatch_mask_d;
      step_count_q    <= step_count_d;
      fail_step_q     <= fail_step_d;
    end
  end

  assign in_ready      = (state_q == LOAD);
  assign step_valid    = (state_q == EVAL);
  assign done          = (state_q == PASS) || (state_q == FAIL);
  assign ok            = (state_q == PASS);
  assign step          = step_q;
  assign err_framing   = err_framing_q;
  assign mismatch_mask = mismatch_mask_q;
  assign step_count    = step_count_q;
  assign fail_step     = fail_step_q;

endmodule

// File: tb/tb_trace_step_sequencer.sv
// Scoreboard bench for trace_step_sequencer: a behavioural tiny86 answers each step,
// expected steps and verdicts are queued as traces are driven and checked as the DUT reports.
module tb_trace_step_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [559:0] step;
  logic         step_valid;
  logic [319:0] post_state;
  logic         done, ok, err_framing;
  logic [9:0]   mismatch_mask;
  logic [31:0]  step_count, fail_step;

  trace_step_sequencer #(.COUNT_W(32), .EFLAGS_MASK(32'h0000_08D5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .step(step), .step_valid(step_valid),
    .post_state(post_state), .done(done), .ok(ok), .err_framing(err_framing),
    .mismatch_mask(mismatch_mask), .step_count(step_count), .fail_step(fail_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done, ok, err;
    logic [9:0]  mask;
    logic [31:0] cnt, fst;
    int          sv;
  } verdict_t;

  logic [559:0] exp_step_q[$];
  verdict_t     exp_v_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int sv_total = 0;
  int sv_base = 0;

  // Behavioural tiny86: eax += 1, eip += 2, everything else carried over.
  function automatic logic [319:0] tiny86(input logic [319:0] r);
    logic [319:0] o;
    o = r;
    o[319:288] = r[319:288] + 32'd1;
    o[63:32]   = r[63:32] + 32'd2;
    return o;
  endfunction

  function automatic logic [559:0] make_step(input logic [319:0] r, input logic [31:0] salt);
    return {salt, ~salt, salt ^ 32'h5A5A_5A5A, r,
            salt + 32'd1, salt + 32'd2, salt + 32'd3, salt + 32'd4, salt[15:0] ^ 16'h1234};
  endfunction

  always_comb post_state = tiny86(step[463:144]);

  task automatic check(input string tag, input logic [559:0] obs, input logic [559:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every EVAL cycle: step must match the next queued step and in_ready must be low.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && step_valid) begin
        sv_total++;
        if (exp_step_q.size() == 0) check("sv_unexpected", 1, 0);
        else check("step_data", step, exp_step_q.pop_front());
        check("rdy_in_eval", in_ready, 0);
        $display("step_valid: step_count=%0d", step_count);
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    sv_base = sv_total;
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_word(input logic [31:0] d, input logic last);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_step(input logic [559:0] s, input int nwords, input logic last,
                           input logic gap);
    logic [31:0] w;
    if (nwords == 18) exp_step_q.push_back(s);
    for (int k = 0; k < nwords; k++) begin
      if (k == 17) w = {s[15:0], 16'hBEEF};
      else         w = s[559-32*k -: 32];
      send_word(w, last && (k == nwords - 1));
      if (gap) @(negedge clk);
    end
  endtask

  task automatic check_verdict(input string tag);
    verdict_t v;
    int t;
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    v = exp_v_q.pop_front();
    check({tag, "_done"}, done, v.done);
    check({tag, "_ok"}, ok, v.ok);
    check({tag, "_err"}, err_framing, v.err);
    check({tag, "_mask"}, mismatch_mask, v.mask);
    check({tag, "_count"}, step_count, v.cnt);
    check({tag, "_fstep"}, fail_step, v.fst);
    check({tag, "_svcyc"}, sv_total - sv_base, v.sv);
    $display("%s: done=%0b ok=%0b err=%0b mask=%b count=%0d fail_step=%0d",
             tag, done, ok, err_framing, mismatch_mask, step_count, fail_step);
  endtask

  logic [319:0] r0, r1, r2;
  logic [559:0] s0, s1, s2;

  initial begin
    r0 = {32'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
          32'h5555_5555, 32'h0000_8000, 32'h0000_9000, 32'h0000_0100, 32'h0000_0044};

    // Reset state
    do_reset(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_step_valid", step_valid, 0);
    check("rst_done", done, 0);
    check("rst_ok", ok, 0);
    check("rst_err", err_framing, 0);
    check("rst_mask", mismatch_mask, 0);
    check("rst_count", step_count, 0);
    check("rst_fstep", fail_step, 0);

    // 1: two chained steps pass
    s0 = make_step(r0, 32'hA000_0001);
    r1 = tiny86(r0);
    s1 = make_step(r1, 32'hA000_0002);
    exp_v_q.push_back('{1, 1, 0, 10'd0, 32'd2, 32'd0, 2});
    send_step(s0, 18, 0, 0);
    send_step(s1, 18, 1, 0);
    check_verdict("t1");

    // 2: ebx mismatch at step 2
    do_reset(2);
    r0[287:256] = 32'd6;
    r1 = tiny86(r0);
    r2 = tiny86(r1);
    r2[287:256] = 32'd5;
    exp_v_q.push_back('{1, 0, 0, 10'b01_0000_0000, 32'd3, 32'd2, 3});
    send_step(make_step(r0, 32'hB000_0000), 18, 0, 0);
    send_step(make_step(r1, 32'hB000_0001), 18, 0, 0);
    send_step(make_step(r2, 32'hB000_0002), 18, 1, 0);
    check_verdict("t2");
    check("t2_rdy_after", in_ready, 0);

    // 3: eflags bit1 difference is ignored
    do_reset(2);
    r1 = tiny86(r0);
    r1[31:0] = r1[31:0] ^ 32'h2;
    exp_v_q.push_back('{1, 1, 0, 10'd0, 32'd2, 32'd0, 2});
    send_step(make_step(r0, 32'hC000_0000), 18, 0, 0);
    send_step(make_step(r1, 32'hC000_0001), 18, 1, 0);
    check_verdict("t3");

    // 3b: eflags CF difference is a mismatch
    do_reset(2);
    r1 = tiny86(r0);
    r1[31:0] = r1[31:0] ^ 32'h1;
    exp_v_q.push_back('{1, 0, 0, 10'b00_0000_0001, 32'd2, 32'd1, 2});
    send_step(make_step(r0, 32'hC100_0000), 18, 0, 0);
    send_step(make_step(r1, 32'hC100_0001), 18, 1, 0);
    check_verdict("t3b");

    // 4: in_last on word 5 is a framing error
    do_reset(2);
    exp_v_q.push_back('{1, 0, 1, 10'd0, 32'd0, 32'd0, 0});
    send_step(make_step(r0, 32'hD000_0000), 6, 1, 0);
    check("t4_done_next", done, 1);
    check_verdict("t4");

    // 5: case 1 with a gap after every word
    do_reset(2);
    r0[287:256] = 32'h1111_1111;
    r1 = tiny86(r0);
    exp_v_q.push_back('{1, 1, 0, 10'd0, 32'd2, 32'd0, 2});
    send_step(make_step(r0, 32'hE000_0000), 18, 0, 1);
    send_step(make_step(r1, 32'hE000_0001), 18, 1, 1);
    check_verdict("t5");

    // 6: reset mid-step, then a fresh single step that disagrees with the stale prediction
    do_reset(2);
    send_step(make_step(r0, 32'hF000_0000), 18, 0, 0);
    send_step(make_step(tiny86(r0), 32'hF000_0001), 9, 0, 0);
    do_reset(1);
    check("t6_rst_count", step_count, 0);
    r2 = r0;
    r2[319:288] = 32'd100;
    exp_v_q.push_back('{1, 1, 0, 10'd0, 32'd1, 32'd0, 1});
    send_step(make_step(r2, 32'hF000_0002), 18, 1, 0);
    check_verdict("t6");

    repeat (3) @(negedge clk);
    check("leftover_steps", exp_step_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
